rs_issue_pick: RTL

Issue picker for one reservation station. It collects per-entry issue requests from the RS entry array and grants the oldest ready entry each cycle. The grant is returned to that entry, which deallocates on it. The winning entry's issue packet is registered into the rs2 stage and held until the execute pipe accepts it. Entry age is tracked with an age matrix updated on every allocation.

---
 rtl/rs_issue_pick.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rs_issue_pick.sv
// Oldest-ready issue picker for one reservation station: an age matrix ranks the
// entries, and the winning entry's packet goes into a single-entry rs2 register.
package rs_issue_pick_pkg;

  typedef struct packed {
    logic [7:0] opcode;
    logic [5:0] rob_id;
    logic [6:0] pdst;
    logic [6:0] psrc1;
    logic [6:0] psrc2;
  } t_uinstr_iss;

endpackage

module rs_issue_pick
  import rs_issue_pick_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int CNT_W       = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic        [NUM_ENTRIES-1:0]       e_alloc_rs0,
  input  logic        [NUM_ENTRIES-1:0]       e_req_issue_rs1,
  input  t_uinstr_iss [NUM_ENTRIES-1:0]       e_issue_pkt_rs1,
  output logic        [NUM_ENTRIES-1:0]       e_gnt_issue_rs1,
  output logic                                iss_valid_rs2,
  output t_uinstr_iss                         iss_pkt_rs2,
  input  logic                                iss_rdy_rs2,
  output logic        [CNT_W-1:0]             issued_cnt
);

  // older_q[i][j] = 1 means entry i was allocated before entry j.
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_q, older_d;
  logic [NUM_ENTRIES-1:0]                  winner;
  logic [NUM_ENTRIES-1:0]                  gnt;
  logic                                    can_issue;
  logic                                    any_gnt;
  t_uinstr_iss                             pick_pkt;

  logic                                    iss_valid_q;
  t_uinstr_iss                             iss_pkt_q;
  logic [CNT_W-1:0]                        issued_cnt_q;

  // A newly allocated entry becomes the youngest: everyone is older than it.
  always_comb begin
    // NOTE: full default assignment first, so no path leaves a bit unassigned and no latch is inferred.
    older_d = older_q;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (e_alloc_rs0[k]) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (i != k) begin
            older_d[i][k] = 1'b1;
            older_d[k][i] = 1'b0;
          end
        end
      end
    end
  end

  // Entry i loses to any requester that is older, or of equal age with a lower index.
  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      winner[i] = e_req_issue_rs1[i];
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (j != i && e_req_issue_rs1[j] &&
            (older_q[j][i] || (!older_q[i][j] && (j < i)))) begin
          winner[i] = 1'b0;
        end
      end
    end
  end

  assign can_issue = ~iss_valid_q | iss_rdy_rs2;
  assign gnt       = reset ? (winner & {NUM_ENTRIES{can_issue}}) : '0;
  assign any_gnt   = |gnt;

  always_comb begin
    pick_pkt = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (gnt[i]) pick_pkt = e_issue_pkt_rs1[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the age matrix is flop-based and tiny, so it is cleared on reset like any other state.
      older_q      <= '0;
      iss_valid_q  <= 1'b0;
      iss_pkt_q    <= '0;
      issued_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      older_q <= older_d;
      if (any_gnt) begin
        iss_pkt_q    <= pick_pkt;
        iss_valid_q  <= 1'b1;
        issued_cnt_q <= issued_cnt_q + CNT_W'(1);
      end else if (iss_rdy_rs2) begin
        iss_valid_q  <= 1'b0;
      end
    end
  end

  assign e_gnt_issue_rs1 = gnt;
  assign iss_valid_rs2   = iss_valid_q;
  assign iss_pkt_rs2     = iss_pkt_q;
  assign issued_cnt      = issued_cnt_q;

`ifndef SYNTHESIS
  a_alloc_onehot0: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(e_alloc_rs0));
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(e_gnt_issue_rs1));
  a_no_alloc_on_gnt: assert property (@(posedge clk) disable iff (!reset)
    (e_alloc_rs0 & e_gnt_issue_rs1) == '0);
  a_gnt_subset_req: assert property (@(posedge clk) disable iff (!reset)
    (e_gnt_issue_rs1 & ~e_req_issue_rs1) == '0);
`endif

endmodule
